// File: rtl/inst_fetch_queue_if.sv
// Fetch/issue handshake bundle for the instruction fetch queue.
// The master drives push data and pops; the slave (the queue) drives status and head entries.
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              flush;
  logic              inst_ok1;
  logic              inst_ok2;
  logic [31:0]       inst_rdata1;
  logic [31:0]       inst_rdata2;
  logic [31:0]       inst_pc;
  logic              full;
  logic              out_valid1;
  logic              out_valid2;
  logic [31:0]       out_inst1;
  logic [31:0]       out_inst2;
  logic [31:0]       out_pc1;
  logic [31:0]       out_pc2;
  logic              pop1;
  logic              pop2;
  logic [PTR_W:0]    count;

  modport master (
    output flush, inst_ok1, inst_ok2, inst_rdata1, inst_rdata2, inst_pc, pop1, pop2,
    input  full, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, count
  );

  modport slave (
    input  flush, inst_ok1, inst_ok2, inst_rdata1, inst_rdata2, inst_pc, pop1, pop2,
    output full, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-write / dual-read instruction FIFO between the I-cache and dual-issue decode.
// Head two entries are presented combinationally; flush empties the queue on redirect.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.slave  fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head1;
  entry_t           head2;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;
  logic             push1;
  logic             push2;
  logic             full_c;
  logic             valid1;
  logic             valid2;

  // Push/pop qualification; full is conservative so a same-cycle pop never admits a push.
  always_comb begin
    full_c    = count_q >= CNT_W'(DEPTH - 1);
    valid1    = count_q >= CNT_W'(1);
    valid2    = count_q >= CNT_W'(2);
    push1     = fq.inst_ok1 & ~full_c & ~fq.flush;
    push2     = push1 & fq.inst_ok2;
    push_n    = CNT_W'(push1) + CNT_W'(push2);
    pop_n     = '0;
    if (!fq.flush) begin
      pop_n = CNT_W'(fq.pop1 & valid1) + CNT_W'(fq.pop1 & fq.pop2 & valid2);
    end
    wr_ptr_p1 = wr_ptr + PTR_W'(1);
    rd_ptr_p1 = rd_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (fq.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(push_n);
      rd_ptr  <= rd_ptr + PTR_W'(pop_n);
      count_q <= count_q + push_n - pop_n;
    end
  end

  // Storage is not reset; only occupancy determines what is visible.
  always_ff @(posedge clk) begin
    if (push1) mem[wr_ptr]    <= {fq.inst_pc, fq.inst_rdata1};
    if (push2) mem[wr_ptr_p1] <= {fq.inst_pc + 32'd4, fq.inst_rdata2};
  end

  assign head1         = mem[rd_ptr];
  assign head2         = mem[rd_ptr_p1];
  assign fq.full       = full_c;
  assign fq.out_valid1 = valid1;
  assign fq.out_valid2 = valid2;
  assign fq.out_inst1  = valid1 ? head1.inst : 32'd0;
  assign fq.out_pc1    = valid1 ? head1.pc   : 32'd0;
  assign fq.out_inst2  = valid2 ? head2.inst : 32'd0;
  assign fq.out_pc2    = valid2 ? head2.pc   : 32'd0;
  assign fq.count      = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus fill, steady-state, flush and reset sequences.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush, ok1, ok2, pop1, pop2;
    logic [31:0] r1, r2, pc;
    logic [31:0] e_cnt;
    logic        e_full, e_v1, e_v2;
    logic [31:0] e_i1, e_i2, e_p1, e_p2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, o1, o2, p1, p2,
                              input logic [31:0] r1, r2, pc, cnt,
                              input logic full, v1, v2,
                              input logic [31:0] i1, i2, pc1, pc2);
    vec_t v;
    v.flush = f;  v.ok1 = o1; v.ok2 = o2; v.pop1 = p1; v.pop2 = p2;
    v.r1 = r1; v.r2 = r2; v.pc = pc; v.e_cnt = cnt;
    v.e_full = full; v.e_v1 = v1; v.e_v2 = v2;
    v.e_i1 = i1; v.e_i2 = i2; v.e_p1 = pc1; v.e_p2 = pc2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, o1, o2, p1, p2, input logic [31:0] r1, r2, pc);
    fq.flush = f; fq.inst_ok1 = o1; fq.inst_ok2 = o2; fq.pop1 = p1; fq.pop2 = p2;
    fq.inst_rdata1 = r1; fq.inst_rdata2 = r2; fq.inst_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] cnt, input logic full, v1, v2,
                         input logic [31:0] i1, i2, p1, p2);
    chk({tag, ".count"}, 32'(fq.count), cnt);
    chk({tag, ".full"},  32'(fq.full), 32'(full));
    chk({tag, ".v1"},    32'(fq.out_valid1), 32'(v1));
    chk({tag, ".v2"},    32'(fq.out_valid2), 32'(v2));
    chk({tag, ".inst1"}, fq.out_inst1, i1);
    chk({tag, ".inst2"}, fq.out_inst2, i2);
    chk({tag, ".pc1"},   fq.out_pc1, p1);
    chk({tag, ".pc2"},   fq.out_pc2, p2);
  endtask

  initial begin
    logic [31:0] pc;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //         f  o1 o2 p1 p2  r1            r2            pc            | cnt full v1 v2 inst1         inst2         pc1           pc2
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'hAAAA0001, 32'hBBBB0002, 32'hBFC00000, 2, 0, 1, 1, 32'hAAAA0001, 32'hBBBB0002, 32'hBFC00000, 32'hBFC00004));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'hCCCC0003, 32'hDDDD0004, 32'h00001000, 3, 0, 1, 1, 32'hAAAA0001, 32'hBBBB0002, 32'hBFC00000, 32'hBFC00004));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hCCCC0003, 32'hDDDD0004, 32'h00002000, 3, 0, 1, 1, 32'hAAAA0001, 32'hBBBB0002, 32'hBFC00000, 32'hBFC00004));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        1, 0, 1, 0, 32'hCCCC0003, 32'h0,        32'h00001000, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'hEEEE0005, 32'hFFFF0006, 32'h80000FFC, 2, 0, 1, 1, 32'hEEEE0005, 32'hFFFF0006, 32'h80000FFC, 32'h80001000));
    vecs.push_back(mk(0, 1, 0, 1, 0, 32'h12340007, 32'h0,        32'h00003000, 2, 0, 1, 1, 32'hFFFF0006, 32'h12340007, 32'h80001000, 32'h00003000));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h12340008, 32'h12340009, 32'hFFFFFFFC, 2, 0, 1, 1, 32'h12340008, 32'h12340009, 32'hFFFFFFFC, 32'h00000000));
    vecs.push_back(mk(1, 1, 1, 1, 1, 32'h1234000A, 32'h1234000B, 32'h00005000, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h1234000A, 32'h1234000B, 32'h00004000, 2, 0, 1, 1, 32'h1234000A, 32'h1234000B, 32'h00004000, 32'h00004004));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        2, 0, 1, 1, 32'h1234000A, 32'h1234000B, 32'h00004000, 32'h00004004));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1, 0, 32'h1234000B, 32'h0,        32'h00004004, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0));

    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].ok1, vecs[i].ok2, vecs[i].pop1, vecs[i].pop2,
            vecs[i].r1, vecs[i].r2, vecs[i].pc);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_v1, vecs[i].e_v2,
              vecs[i].e_i1, vecs[i].e_i2, vecs[i].e_p1, vecs[i].e_p2);
    end

    // Fill to DEPTH-1, confirm pushes are blocked while full even alongside a pop.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 7; k++) begin
      pc = 32'h1000 + 32'(8 * k);
      drive(0, 1, 1, 0, 0, pc ^ 32'h5A5A0000, (pc + 32'd4) ^ 32'h5A5A0000, pc);
      step();
    end
    chk("fill14.count", 32'(fq.count), 14);
    chk("fill14.full",  32'(fq.full), 0);
    drive(0, 1, 0, 0, 0, 32'h1038 ^ 32'h5A5A0000, 0, 32'h1038);
    step();
    chk("fill15.count", 32'(fq.count), 15);
    chk("fill15.full",  32'(fq.full), 1);
    drive(0, 1, 1, 0, 0, 32'hDEAD0000, 32'hDEAD0004, 32'h9000);
    step();
    chk("fullblk.count", 32'(fq.count), 15);
    drive(0, 1, 1, 1, 0, 32'hDEAD0000, 32'hDEAD0004, 32'h9000);
    step();
    chk("fullpop.count", 32'(fq.count), 14);
    chk("fullpop.full",  32'(fq.full), 0);
    chk("fullpop.pc1",   fq.out_pc1, 32'h1004);
    chk("fullpop.inst2", fq.out_inst2, 32'h1008 ^ 32'h5A5A0000);
    drive(0, 1, 1, 0, 0, 32'h103C ^ 32'h5A5A0000, 32'h1040 ^ 32'h5A5A0000, 32'h103C);
    step();
    chk("fill16.count", 32'(fq.count), 16);
    chk("fill16.full",  32'(fq.full), 1);

    // Steady state: dual push + dual pop each cycle across pointer wrap.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 0, 0, 32'h2000 ^ 32'h5A5A0000, 32'h2004 ^ 32'h5A5A0000, 32'h2000);
    step();
    for (int c = 0; c < 40; c++) begin
      pc = 32'h2000 + 32'(8 * (c + 1));
      drive(0, 1, 1, 1, 1, pc ^ 32'h5A5A0000, (pc + 32'd4) ^ 32'h5A5A0000, pc);
      step();
      chk($sformatf("steady%0d.count", c), 32'(fq.count), 2);
      chk($sformatf("steady%0d.pc1", c),   fq.out_pc1, pc);
      chk($sformatf("steady%0d.inst2", c), fq.out_inst2, (pc + 32'd4) ^ 32'h5A5A0000);
    end

    // Flush at count 6 with push and pop asserted.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 32'h11110000, 32'h22220000, 32'h6000 + 32'(8 * k));
      step();
    end
    chk("pre_flush.count", 32'(fq.count), 6);
    drive(1, 1, 1, 1, 1, 32'h33330000, 32'h44440000, 32'h7000);
    step();
    chk_all("flush", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-traffic clears outputs without waiting for a clock.
    drive(0, 1, 1, 0, 0, 32'h55550000, 32'h66660000, 32'h8000);
    step();
    chk("pre_rst.count", 32'(fq.count), 2);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    step();
    chk("post_rst.count", 32'(fq.count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
